ptr_pool_arbiter: RTL and testbench

Owns the pool of linked-list node pointers and shares it between several request generators. It keeps a free list as an on-chip linked list of `next` pointers and round-robins the allocation requests. It returns one free pointer per cycle to the granted requester and accepts one released pointer per cycle. It sits between the `req_gen` instances and the list storage, and drives the pointer/valid pair that reaches the HEX0/LEDR debug display.

---
 rtl/ptr_pool_arbiter.sv | 136 +++++++++++++
 tb/tb_ptr_pool_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ptr_pool_arbiter.sv
// Free-pointer pool for linked-list nodes: on-chip FIFO free list of `next` links,
// round-robin allocation among N_REQ requesters, one alloc and one free per cycle.
module ptr_pool_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] alloc_req,
    output logic [N_REQ-1:0] alloc_gnt,
    output logic [PTR_W-1:0] alloc_ptr,
    output logic             alloc_vld,
    input  logic             free_vld,
    input  logic [PTR_W-1:0] free_ptr,
    output logic [PTR_W:0]   free_cnt,
    output logic             empty,
    output logic             ready,
    output logic             err
);

    localparam int DEPTH = 2 ** PTR_W;
    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0] FULL = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0] ONE  = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [PTR_W-1:0]  init_idx;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [RR_W-1:0]   rr_last;
    logic [PTR_W-1:0]  next_mem [DEPTH];

    logic              found;
    logic [RR_W-1:0]   idx;
    logic [RR_W-1:0]   gnt_idx;
    logic              do_alloc;
    logic              do_free;
    logic [PTR_W:0]    cnt_nxt;

    // Round-robin scan starting just after the last winner, with wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        alloc_gnt = '0;
        found     = 1'b0;
        idx       = '0;
        gnt_idx   = '0;
        if (state == RUN && free_cnt != '0) begin
            for (int i = 1; i <= N_REQ; i++) begin
                idx = RR_W'((int'(rr_last) + i) % N_REQ);
                if (!found && alloc_req[idx]) begin
                    found          = 1'b1;
                    alloc_gnt[idx] = 1'b1;
                    gnt_idx        = idx;
                end
            end
        end
    end

    assign alloc_vld = found;
    assign alloc_ptr = head;

    always_comb begin
        do_alloc = found;
        do_free  = (state == RUN) && free_vld && (free_cnt != FULL);
        cnt_nxt  = free_cnt;
        if (state == INIT) begin
            cnt_nxt = {1'b0, init_idx} + 1'b1;
        end else if (do_alloc && !do_free) begin
            cnt_nxt = free_cnt - 1'b1;
        end else if (do_free && !do_alloc) begin
            cnt_nxt = free_cnt + 1'b1;
        end
    end

    // NOTE: the link array is deliberately not reset; INIT rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                next_mem[init_idx] <= init_idx + 1'b1;
            end else if (do_free) begin
                next_mem[tail] <= free_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_idx <= '0;
            head     <= '0;
            tail     <= '0;
            free_cnt <= '0;
            empty    <= 1'b1;
            ready    <= 1'b0;
            err      <= 1'b0;
            rr_last  <= RR_W'(N_REQ - 1);
        end else begin
            free_cnt <= cnt_nxt;
            empty    <= (cnt_nxt == '0);
            case (state)
                INIT: begin
                    tail     <= init_idx;
                    init_idx <= init_idx + 1'b1;
                    if (&init_idx) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (free_vld && free_cnt == FULL) begin
                        err <= 1'b1;
                    end
                    if (do_alloc) begin
                        rr_last <= gnt_idx;
                    end
                    if (do_free) begin
                        tail <= free_ptr;
                    end
                    // With a single node left, head and tail coincide, so the freed
                    // pointer becomes the new head instead of the stale link.
                    if (do_alloc && do_free && free_cnt == ONE) begin
                        head <= free_ptr;
                    end else if (do_alloc) begin
                        head <= next_mem[head];
                    end else if (do_free && free_cnt == '0) begin
                        head <= free_ptr;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ptr_pool_arbiter.sv
// Directed bench for ptr_pool_arbiter: table of per-cycle vectors for round-robin,
// exhaustion and refill, plus hand-written sequences for init, same-cycle alloc/free,
// free-while-full and reset mid-operation.
module tb_ptr_pool_arbiter;

    localparam int N_REQ = 4;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] alloc_req;
    logic [N_REQ-1:0] alloc_gnt;
    logic [PTR_W-1:0] alloc_ptr;
    logic             alloc_vld;
    logic             free_vld;
    logic [PTR_W-1:0] free_ptr;
    logic [PTR_W:0]   free_cnt;
    logic             empty;
    logic             ready;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       fv;
        logic [3:0] fp;
        logic [3:0] gnt;
        logic [3:0] ptr;
        logic       chk_ptr;
        logic [4:0] cnt;
    } vec_t;

    vec_t vecs[$];

    ptr_pool_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_ptr (alloc_ptr),
        .alloc_vld (alloc_vld),
        .free_vld  (free_vld),
        .free_ptr  (free_ptr),
        .free_cnt  (free_cnt),
        .empty     (empty),
        .ready     (ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for n edges with every requester asserted, then checks INIT lasts 16 cycles.
    task automatic reset_and_init(input int n);
        rst_n     = 1'b0;
        alloc_req = 4'b1111;
        free_vld  = 1'b0;
        free_ptr  = '0;
        repeat (n) step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("init_ready[%0d]", i), ready, 0);
            check($sformatf("init_gnt[%0d]", i), alloc_gnt, 0);
            step();
        end
        @(negedge clk);
        check("ready_after_init", ready, 1);
        check("cnt_after_init", free_cnt, 16);
        check("ptr_after_init", alloc_ptr, 0);
        check("err_after_init", err, 0);
        alloc_req = '0;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        alloc_req = '0;
        free_vld  = 1'b0;
        free_ptr  = '0;

        // 16 allocations with all requesting: grants rotate 0,1,2,3 and pointers 0..15 in order.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            vecs.push_back('{4'b1111, 1'b0, 4'd0, g, 4'(i), 1'b1, 5'(16 - i)});
        end
        vecs.push_back('{4'b0100, 1'b0, 4'd0, 4'b0000, 4'd0, 1'b0, 5'd0});
        vecs.push_back('{4'b0100, 1'b1, 4'd5, 4'b0000, 4'd0, 1'b0, 5'd0});
        vecs.push_back('{4'b0100, 1'b0, 4'd0, 4'b0100, 4'd5, 1'b1, 5'd1});
        vecs.push_back('{4'b0000, 1'b0, 4'd0, 4'b0000, 4'd0, 1'b0, 5'd0});

        // Reset and init, then round-robin, exhaust and refill.
        reset_and_init(2);
        foreach (vecs[k]) begin
            alloc_req = vecs[k].req;
            free_vld  = vecs[k].fv;
            free_ptr  = vecs[k].fp;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", k), alloc_gnt, vecs[k].gnt);
            check($sformatf("vec%0d_vld", k), alloc_vld, |vecs[k].gnt);
            if (vecs[k].chk_ptr) check($sformatf("vec%0d_ptr", k), alloc_ptr, vecs[k].ptr);
            check($sformatf("vec%0d_cnt", k), free_cnt, vecs[k].cnt);
            check($sformatf("vec%0d_empty", k), empty, vecs[k].cnt == 0);
            step();
        end
        free_vld = 1'b0;

        // Alloc and free in the same cycle with one node left (head = 15).
        reset_and_init(2);
        alloc_req = 4'b0001;
        repeat (15) step();
        free_vld = 1'b1;
        free_ptr = 4'd3;
        @(negedge clk);
        check("same_cycle_cnt_before", free_cnt, 1);
        check("same_cycle_gnt", alloc_gnt, 4'b0001);
        check("same_cycle_ptr", alloc_ptr, 15);
        step();
        free_vld  = 1'b0;
        alloc_req = '0;
        @(negedge clk);
        check("same_cycle_head", alloc_ptr, 3);
        check("same_cycle_cnt_after", free_cnt, 1);
        check("same_cycle_empty", empty, 0);
        step();
        alloc_req = 4'b0001;
        @(negedge clk);
        check("same_cycle_regrant", alloc_gnt, 4'b0001);
        check("same_cycle_reptr", alloc_ptr, 3);
        step();
        alloc_req = '0;
        @(negedge clk);
        check("same_cycle_drained", free_cnt, 0);
        check("same_cycle_empty_end", empty, 1);
        step();

        // Free while full sets the sticky error and leaves the list untouched.
        reset_and_init(2);
        free_vld = 1'b1;
        free_ptr = 4'd7;
        step();
        free_vld = 1'b0;
        @(negedge clk);
        check("full_free_err", err, 1);
        check("full_free_cnt", free_cnt, 16);
        repeat (3) step();
        @(negedge clk);
        check("full_free_err_sticky", err, 1);
        alloc_req = 4'b0001;
        #1;
        check("full_free_gnt", alloc_gnt, 4'b0001);
        check("full_free_ptr", alloc_ptr, 0);
        step();
        alloc_req = '0;

        // Reset mid-operation clears error, count and round-robin pointer.
        reset_and_init(2);
        free_vld = 1'b1;
        free_ptr = 4'd7;
        step();
        free_vld  = 1'b0;
        alloc_req = 4'b1111;
        repeat (6) step();
        @(negedge clk);
        check("mid_cnt_before_reset", free_cnt, 10);
        check("mid_err_before_reset", err, 1);
        step();
        reset_and_init(1);
        alloc_req = 4'b1111;
        @(negedge clk);
        check("mid_first_gnt", alloc_gnt, 4'b0001);
        check("mid_first_ptr", alloc_ptr, 0);
        check("mid_err", err, 0);
        step();
        alloc_req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
